// File: rtl/fetch_unit.sv
// fetch_unit: byte-wide instruction fetch front end. Assembles 1/2-byte instructions,
// fetches the data operand byte, and hands {inst, data, pc} to execute over valid/ready.
`default_nettype none
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] inst,
  output logic [7:0]  data,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [2:0] {
    FETCH_OP   = 3'd0,
    FETCH_ARG  = 3'd1,
    FETCH_DATA = 3'd2,
    HOLD       = 3'd3,
    DRAIN      = 3'd4
  } state_t;

  state_t      r_state, w_state_n;
  logic [15:0] r_pc, w_pc_n;
  logic [15:0] w_inst_n, w_inst_pc_n, w_addr_n;
  logic [7:0]  w_data_n;
  logic        w_valid_n, w_rd_n;
  logic        w_ack, w_data_src;

  assign w_ack      = mem_rd & mem_ack;
  // Data-source opcodes carry an operand address in their second byte.
  assign w_data_src = (inst[15:14] == 2'b10) && (inst[10:9] == 2'b01);

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_inst_n    = inst;
    w_data_n    = data;
    w_inst_pc_n = inst_pc;
    w_valid_n   = inst_valid;
    w_rd_n      = 1'b0;
    w_addr_n    = mem_addr;

    case (r_state)
      FETCH_OP: begin
        if (w_ack) begin
          w_inst_n[15:8] = mem_rdata;
          w_inst_pc_n    = r_pc;
          w_pc_n         = r_pc + 16'd1;
          if (!mem_rdata[7]) begin
            w_inst_n[7:0] = 8'h00;
            w_data_n      = 8'h00;
            w_valid_n     = 1'b1;
            w_state_n     = HOLD;
          end else begin
            w_state_n = FETCH_ARG;
          end
        end
      end
      FETCH_ARG: begin
        if (w_ack) begin
          w_inst_n[7:0] = mem_rdata;
          w_pc_n        = r_pc + 16'd1;
          if (w_data_src) begin
            w_state_n = FETCH_DATA;
          end else begin
            w_data_n  = 8'h00;
            w_valid_n = 1'b1;
            w_state_n = HOLD;
          end
        end
      end
      FETCH_DATA: begin
        if (w_ack) begin
          w_data_n  = mem_rdata;
          w_valid_n = 1'b1;
          w_state_n = HOLD;
        end
      end
      HOLD: begin
        if (inst_valid && inst_ready) begin
          w_valid_n = 1'b0;
          w_state_n = FETCH_OP;
        end
      end
      DRAIN: begin
        if (w_ack) w_state_n = FETCH_OP;
      end
      default: w_state_n = FETCH_OP;
    endcase

    // Redirect overrides everything; an unacked read must be drained first.
    if (redirect) begin
      w_valid_n = 1'b0;
      w_pc_n    = redirect_pc;
      w_state_n = (mem_rd && !mem_ack) ? DRAIN : FETCH_OP;
    end

    case (w_state_n)
      DRAIN: begin
        w_rd_n   = 1'b1;
        w_addr_n = mem_addr;
      end
      FETCH_OP, FETCH_ARG: begin
        w_rd_n   = 1'b1;
        w_addr_n = w_pc_n;
      end
      FETCH_DATA: begin
        w_rd_n   = 1'b1;
        w_addr_n = {8'h00, w_inst_n[7:0]};
      end
      default: begin
        w_rd_n   = 1'b0;
        w_addr_n = mem_addr;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH_OP;
      r_pc       <= RESET_PC;
      mem_rd     <= 1'b0;
      mem_addr   <= RESET_PC;
      inst       <= 16'h0000;
      data       <= 8'h00;
      inst_pc    <= 16'h0000;
      inst_valid <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      mem_rd     <= w_rd_n;
      mem_addr   <= w_addr_n;
      inst       <= w_inst_n;
      data       <= w_data_n;
      inst_pc    <= w_inst_pc_n;
      inst_valid <= w_valid_n;
    end
  end

endmodule

`default_nettype wire
